localbus_stream_tx: RTL and testbench
=====================================

// Module: localbus_stream_tx
// PURPOSE
//  Local-bus transmitter fed by a unit stream (valid/ready). Drives the DE/DQ0/DQ1/CLK_O
//  serial format that localbus_parser consumes.
//  - Per clock: even bits on DQ0, odd bits on DQ1, LSB first. Unit 0 of each group is sent first.
//  - Sends CYCLE_NUM groups of UNIT_NUM units per frame.
//  - Sits between a command/register source FIFO and the board-level local-bus pins.
// PARAMETERS
//  UNIT_BIT_NUM    32  bits per unit; must be even and >=4
//  MAX_UNIT_NUM    4   maximum units per group
//  INTER_CYCLE_GAP 0   bit periods with DE low between groups; 0 = DE stays high across the frame
// PORTS
//  CLK_I          in   1             system clock; the only clock
//  RST_I          in   1             synchronous reset, active-high
//  START_I        in   1             frame request; sampled only in IDLE
//  UNIT_NUM_I     in   8             units per group, 1..MAX_UNIT_NUM; latched on START
//  CYCLE_NUM_I    in   8             groups per frame, 1..255; latched on START
//  UNIT_DATA_I    in   UNIT_BIT_NUM  unit payload
//  UNIT_VALID_I   in   1             payload valid
//  UNIT_READY_O   out  1             holding register empty; transfer on VALID&READY
//  CLK_O          out  1             bus clock = CLK_I/2, free-running
//  DE_O           out  1             data enable
//  DQ0_O          out  1             even bit of current pair
//  DQ1_O          out  1             odd bit of current pair
//  BUSY_O         out  1             high from accepted START to frame end
//  DONE_O         out  1             1-cycle pulse at normal frame end
//  UNDERRUN_O     out  1             1-cycle pulse when a frame is aborted for lack of data
// BEHAVIOUR
//  - Reset: CLK_O=0, DE_O=0, DQ0_O=0, DQ1_O=0, UNIT_READY_O=0, BUSY_O=0, DONE_O=0, UNDERRUN_O=0.
//    Holding register is cleared; FSM goes to IDLE.
//  - Phase: a 1-bit phase toggles every CLK_I, and CLK_O equals the phase.
//    DQ/DE update only in the cycle where CLK_O goes 0. Data is therefore stable for 2 CLK_I
//    cycles and centred on the CLK_O rising edge.
//  - FSM:
//    - IDLE -> FILL on START_I with UNIT_NUM_I in 1..MAX_UNIT_NUM and CYCLE_NUM_I != 0.
//      Any other START is ignored; no pulse is produced.
//    - FILL: READY=1 until the first unit is held. Then wait for the next CLK_O-low slot -> SHIFT.
//    - SHIFT: load the held unit into the shift register, DE_O=1, and drive bits[1:0].
//      Shift right by 2 each bit period, UNIT_BIT_NUM/2 periods per unit.
//      READY=1 whenever the holding register is empty, so the next unit is prefetched.
//    - Unit boundary inside a group:
//      - holding register full -> load it seamlessly, with no DE drop and no extra period.
//      - holding register empty -> UNDERRUN.
//    - Group boundary:
//      - CYCLE count remaining and INTER_CYCLE_GAP > 0 -> GAP (DE=0, DQ=0 for GAP periods) -> SHIFT.
//      - CYCLE count remaining and INTER_CYCLE_GAP = 0 -> same rule as a unit boundary.
//      - Last unit of last group -> END.
//    - END: DE_O=0, DQ=0 at the next slot; DONE_O pulses; BUSY_O drops the same cycle -> IDLE.
//    - UNDERRUN: DE_O=0 at the slot; UNDERRUN_O pulses; the held unit is discarded;
//      BUSY_O drops -> IDLE.
//  - Frame sizes:
//    - Bit periods per frame = UNIT_NUM*CYCLE_NUM*UNIT_BIT_NUM/2 + (CYCLE_NUM-1)*INTER_CYCLE_GAP.
//    - Counters: unit count 8b, cycle count 8b, pair count $clog2(UNIT_BIT_NUM/2)+1 bits.
//  - Latency: START accepted at cycle t with VALID already high. The unit is captured at t+1.
//    DE_O rises at t+2 or t+3, depending on phase.
//  - UNIT_READY_O=0 in IDLE and END: no unit is consumed outside a frame.
//    Units beyond the frame total are never accepted.
//  - START_I while BUSY is ignored. Changes to UNIT_NUM_I/CYCLE_NUM_I mid-frame have no effect.
//  - Reset mid-frame: all outputs return to reset values on the next edge. No DONE/UNDERRUN pulse.
// STRUCTURE
//  - localbus_pkg holds: FSM state enum (IDLE, FILL, SHIFT, GAP, END, UNDERRUN) and
//    localparam PAIRS = UNIT_BIT_NUM/2.
//    The same package will be shared with localbus_parser/localbus_sender.
//  - Sub-module localbus_clk_phase: divide-by-2 phase, CLK_O, and the one-cycle slot strobe
//    at the CLK_O falling edge.
// TESTING
//  Loop back through localbus_parser (MODE=1 unless noted, UNIT_BIT_NUM=32).
//  1. Basic frame.
//     - Stimulus: UNIT_NUM=4, CYCLE=1; units 0xaa55aa55, 0x55667788, 0x11223344, 0xffeeddcc;
//       VALID always high.
//     - Response:
//       - DE high for exactly 128 CLK_I.
//       - First 4 periods DQ0=1/DQ1=0, next 4 periods DQ0=0/DQ1=1.
//       - Parser LB_DATA_0..3 match the units; one DONE pulse.
//  2. Multi-cycle with gap.
//     - Stimulus: INTER_CYCLE_GAP=2, UNIT_NUM=2, CYCLE=3; parser MODE=0.
//     - Response: three 32-period DE bursts separated by 4 CLK_I of DE low;
//       parser FINISH_0/1 fire 3 times; DONE once.
//  3. Underrun.
//     - Stimulus: UNIT_NUM=2; VALID dropped after the first unit.
//     - Response: DE falls after 16 periods; UNDERRUN pulse; BUSY=0;
//       no DONE; READY=0 in IDLE afterwards.
//  4. Illegal start.
//     - Stimulus: START with UNIT_NUM=0, then with CYCLE_NUM=0, then UNIT_NUM=5.
//     - Response: BUSY stays 0, DE stays 0, READY stays 0, no pulses.
//  5. Back-pressure / stall-free.
//     - Stimulus: VALID toggles 1-0 each cycle.
//     - Response: DE remains continuous across units; bit stream identical to scenario 1.
//  6. Reset mid-frame.
//     - Stimulus: RST_I for 1 cycle at period 40, then a new START.
//     - Response: all outputs at reset values; the next frame transmits correctly from unit 0.

Source files
------------

// File: rtl/localbus_pkg.sv
// Shared local-bus definitions: FSM states, datapath actions and unit geometry.
// Also intended for localbus_parser / localbus_sender.
package localbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        GAP,
        END,
        UNDERRUN
    } lb_state_e;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_SHIFT,
        ACT_BLANK
    } lb_act_e;

    localparam int UNIT_BIT_NUM_DEF = 32;
    localparam int PAIRS            = UNIT_BIT_NUM_DEF / 2;

    function automatic int pairs_of(input int unit_bits);
        return unit_bits / 2;
    endfunction

endpackage

// File: rtl/localbus_stream_tx_if.sv
// Unit-stream input and local-bus pin bundle of localbus_stream_tx.
// master = unit source / frame requester, slave = transmitter.
interface localbus_stream_tx_if #(
    parameter int UNIT_BIT_NUM = 32
);
    logic                    START_I;
    logic [7:0]              UNIT_NUM_I;
    logic [7:0]              CYCLE_NUM_I;
    logic [UNIT_BIT_NUM-1:0] UNIT_DATA_I;
    logic                    UNIT_VALID_I;
    logic                    UNIT_READY_O;
    logic                    CLK_O;
    logic                    DE_O;
    logic                    DQ0_O;
    logic                    DQ1_O;
    logic                    BUSY_O;
    logic                    DONE_O;
    logic                    UNDERRUN_O;

    modport master (
        output START_I, UNIT_NUM_I, CYCLE_NUM_I, UNIT_DATA_I, UNIT_VALID_I,
        input  UNIT_READY_O, CLK_O, DE_O, DQ0_O, DQ1_O, BUSY_O, DONE_O, UNDERRUN_O
    );

    modport slave (
        input  START_I, UNIT_NUM_I, CYCLE_NUM_I, UNIT_DATA_I, UNIT_VALID_I,
        output UNIT_READY_O, CLK_O, DE_O, DQ0_O, DQ1_O, BUSY_O, DONE_O, UNDERRUN_O
    );
endinterface

// File: rtl/localbus_clk_phase.sv
// Divide-by-2 bus clock. SLOT_O marks the cycle whose closing edge drops CLK_O,
// so anything updated on a slot changes together with the CLK_O falling edge.
module localbus_clk_phase (
    input  logic CLK_I,
    input  logic RST_I,
    output logic CLK_O,
    output logic SLOT_O
);
    logic phase_q, phase_d;

    assign phase_d = ~phase_q;

    always_ff @(posedge CLK_I) begin
        if (RST_I) phase_q <= 1'b0;
        else       phase_q <= phase_d;
    end

    assign CLK_O  = phase_q;
    assign SLOT_O = phase_q;
endmodule

// File: rtl/localbus_stream_tx.sv
// Local-bus transmitter: serialises units from a valid/ready stream onto DE/DQ0/DQ1,
// two bits per CLK_O period, LSB first, with one-unit prefetch through a holding register.
module localbus_stream_tx
    import localbus_pkg::*;
#(
    parameter int UNIT_BIT_NUM    = 32,
    parameter int MAX_UNIT_NUM    = 4,
    parameter int INTER_CYCLE_GAP = 0
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    localbus_stream_tx_if.slave bus
);
    localparam int NPAIRS = pairs_of(UNIT_BIT_NUM);
    localparam int PCW    = $clog2(NPAIRS) + 1;
    localparam int GAP_W  = $clog2(INTER_CYCLE_GAP + 1) + 1;

    lb_state_e               state_q, state_d;
    lb_act_e                 act;
    logic [UNIT_BIT_NUM-1:0] hold_q, hold_d, sh_q, sh_d;
    logic                    hold_full_q, hold_full_d;
    logic [PCW-1:0]          pair_q, pair_d;
    logic [7:0]              unit_q, unit_d, cyc_q, cyc_d, un_q, un_d;
    logic [15:0]             fetch_q, fetch_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    de_q, de_d, dq0_q, dq0_d, dq1_q, dq1_d;
    logic                    slot, bus_clk, active, ready, accept, start_ok;

    localbus_clk_phase u_phase (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .CLK_O  (bus_clk),
        .SLOT_O (slot)
    );

    assign active   = (state_q == FILL) || (state_q == SHIFT) || (state_q == GAP);
    // fetch_q counts units still to be accepted, so nothing past the frame total is taken
    assign ready    = active && !hold_full_q && (fetch_q != 16'd0);
    assign accept   = ready && bus.UNIT_VALID_I;
    assign start_ok = bus.START_I && (bus.UNIT_NUM_I != 8'd0) &&
                      (bus.UNIT_NUM_I <= 8'(MAX_UNIT_NUM)) && (bus.CYCLE_NUM_I != 8'd0);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        pair_d      = pair_q;
        unit_d      = unit_q;
        cyc_d       = cyc_q;
        un_d        = un_q;
        fetch_d     = fetch_q;
        gap_d       = gap_q;
        de_d        = de_q;
        dq0_d       = dq0_q;
        dq1_d       = dq1_q;
        act         = ACT_HOLD;

        if (accept) begin
            hold_d      = bus.UNIT_DATA_I;
            hold_full_d = 1'b1;
            fetch_d     = fetch_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FILL;
                    un_d    = bus.UNIT_NUM_I;
                    unit_d  = bus.UNIT_NUM_I - 8'd1;
                    cyc_d   = bus.CYCLE_NUM_I - 8'd1;
                    fetch_d = {8'd0, bus.UNIT_NUM_I} * {8'd0, bus.CYCLE_NUM_I};
                end
            end
            FILL: begin
                if (slot && hold_full_q) begin
                    act     = ACT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (slot) begin
                    if (pair_q != '0) begin
                        act = ACT_SHIFT;
                    end else if (unit_q != 8'd0) begin
                        unit_d = unit_q - 8'd1;
                        if (hold_full_q) begin
                            act = ACT_LOAD;
                        end else begin
                            act     = ACT_BLANK;
                            state_d = UNDERRUN;
                        end
                    end else if (cyc_q != 8'd0) begin
                        cyc_d  = cyc_q - 8'd1;
                        unit_d = un_q - 8'd1;
                        if (INTER_CYCLE_GAP != 0) begin
                            act     = ACT_BLANK;
                            state_d = GAP;
                            gap_d   = GAP_W'(INTER_CYCLE_GAP - 1);
                        end else if (hold_full_q) begin
                            act = ACT_LOAD;
                        end else begin
                            act     = ACT_BLANK;
                            state_d = UNDERRUN;
                        end
                    end else begin
                        act     = ACT_BLANK;
                        state_d = END;
                    end
                end
            end
            GAP: begin
                if (slot) begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else if (hold_full_q) begin
                        act     = ACT_LOAD;
                        state_d = SHIFT;
                    end else begin
                        act     = ACT_BLANK;
                        state_d = UNDERRUN;
                    end
                end
            end
            END: begin
                state_d = IDLE;
            end
            UNDERRUN: begin
                // a unit may have slipped in on the aborting slot; drop it
                state_d     = IDLE;
                hold_full_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (act)
            ACT_LOAD: begin
                sh_d        = hold_q >> 2;
                dq0_d       = hold_q[0];
                dq1_d       = hold_q[1];
                de_d        = 1'b1;
                pair_d      = PCW'(NPAIRS - 1);
                hold_full_d = 1'b0;
            end
            ACT_SHIFT: begin
                sh_d   = sh_q >> 2;
                dq0_d  = sh_q[0];
                dq1_d  = sh_q[1];
                pair_d = pair_q - PCW'(1);
            end
            ACT_BLANK: begin
                de_d  = 1'b0;
                dq0_d = 1'b0;
                dq1_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            pair_q      <= '0;
            unit_q      <= '0;
            cyc_q       <= '0;
            un_q        <= '0;
            fetch_q     <= '0;
            gap_q       <= '0;
            de_q        <= 1'b0;
            dq0_q       <= 1'b0;
            dq1_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            pair_q      <= pair_d;
            unit_q      <= unit_d;
            cyc_q       <= cyc_d;
            un_q        <= un_d;
            fetch_q     <= fetch_d;
            gap_q       <= gap_d;
            de_q        <= de_d;
            dq0_q       <= dq0_d;
            dq1_q       <= dq1_d;
        end
    end

    assign bus.UNIT_READY_O = ready;
    assign bus.CLK_O        = bus_clk;
    assign bus.DE_O         = de_q;
    assign bus.DQ0_O        = dq0_q;
    assign bus.DQ1_O        = dq1_q;
    assign bus.BUSY_O       = active;
    assign bus.DONE_O       = (state_q == END);
    assign bus.UNDERRUN_O   = (state_q == UNDERRUN);
endmodule

// File: tb/tb_localbus_stream_tx.sv
// Bench for localbus_stream_tx: a receiver model rebuilds units from DE/DQ on CLK_O high
// and pops them against a scoreboard of expected units.
module tb_localbus_stream_tx;
    import localbus_pkg::*;

    localparam int UBN = 32;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;
    always #5 CLK_I = ~CLK_I;

    localbus_stream_tx_if #(.UNIT_BIT_NUM(UBN)) bus ();

    localbus_stream_tx #(
        .UNIT_BIT_NUM    (UBN),
        .MAX_UNIT_NUM    (4),
        .INTER_CYCLE_GAP (2)
    ) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [UBN-1:0] src_q[$];
    logic [UBN-1:0] exp_q[$];
    bit toggle_mode = 1'b0;
    bit allow_partial = 1'b0;
    bit mon_en = 1'b0;
    int de_cyc, bursts, done_cnt, und_cnt, rdy_cyc, low_run, rx_n;
    int gaps[$];
    logic [UBN-1:0] rx_sh;
    logic prev_de = 1'b0;

    // unit source: advances only on an observed VALID&READY handshake
    initial begin
        bit hs;
        bit tog;
        tog = 1'b0;
        bus.UNIT_VALID_I = 1'b0;
        bus.UNIT_DATA_I  = '0;
        forever begin
            @(negedge CLK_I);
            hs = bus.UNIT_VALID_I && bus.UNIT_READY_O;
            @(posedge CLK_I);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            tog = !tog;
            if (src_q.size() > 0 && (!toggle_mode || tog)) begin
                bus.UNIT_VALID_I = 1'b1;
                bus.UNIT_DATA_I  = src_q[0];
            end else begin
                bus.UNIT_VALID_I = 1'b0;
                bus.UNIT_DATA_I  = '0;
            end
        end
    end

    // receiver model and scoreboard
    always @(negedge CLK_I) begin
        logic [UBN-1:0] exp;
        if (mon_en) begin
            if (bus.DE_O) de_cyc++;
            if (bus.UNIT_READY_O) rdy_cyc++;
            if (bus.DONE_O) done_cnt++;
            if (bus.UNDERRUN_O) und_cnt++;
            if (bus.DE_O && !prev_de) begin
                if (bursts > 0) gaps.push_back(low_run);
                bursts++;
            end
            low_run = bus.DE_O ? 0 : low_run + 1;
            prev_de = bus.DE_O;
            if (!bus.DE_O) begin
                checks++;
                if (bus.DQ0_O !== 1'b0 || bus.DQ1_O !== 1'b0) begin
                    errors++;
                    $display("FAIL dq_idle: dq1/dq0=%b%b, expected 00 while DE low at %0t", bus.DQ1_O, bus.DQ0_O, $time);
                end
            end
            if (bus.CLK_O && bus.DE_O) begin
                rx_sh = {bus.DQ1_O, bus.DQ0_O, rx_sh[UBN-1:2]};
                rx_n++;
                if (rx_n == PAIRS) begin
                    rx_n = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unit: got %h, no unit expected at %0t", rx_sh, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        if (rx_sh !== exp) begin
                            errors++;
                            $display("FAIL rx_unit: got %h expected %h at %0t", rx_sh, exp, $time);
                        end
                    end
                end
            end else if (bus.CLK_O && rx_n != 0) begin
                if (!allow_partial) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_partial: DE dropped after %0d pairs, expected %0d at %0t", rx_n, PAIRS, $time);
                end
                rx_n = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    task automatic clear_mon();
        de_cyc = 0; bursts = 0; done_cnt = 0; und_cnt = 0;
        rdy_cyc = 0; low_run = 0; rx_n = 0;
        gaps.delete();
    endtask

    task automatic start_frame(input logic [7:0] un, input logic [7:0] cn);
        @(posedge CLK_I);
        #1;
        bus.UNIT_NUM_I  = un;
        bus.CYCLE_NUM_I = cn;
        bus.START_I     = 1'b1;
        @(posedge CLK_I);
        #1;
        bus.START_I = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK_I);
            #1;
            if (!bus.BUSY_O) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick(3);
    endtask

    function automatic logic [7:0] out_vec();
        return {bus.CLK_O, bus.DE_O, bus.DQ0_O, bus.DQ1_O,
                bus.UNIT_READY_O, bus.BUSY_O, bus.DONE_O, bus.UNDERRUN_O};
    endfunction

    task automatic test_reset();
        logic c0;
        tick(3);
        checks++;
        if (out_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", out_vec());
        end
        RST_I = 1'b0;
        tick(1);
        c0 = bus.CLK_O;
        tick(1);
        checks++;
        if (bus.CLK_O !== ~c0 || bus.BUSY_O !== 1'b0 || bus.UNIT_READY_O !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: clk_o %b->%b busy=%b ready=%b, expected toggle, 0, 0",
                     c0, bus.CLK_O, bus.BUSY_O, bus.UNIT_READY_O);
        end
        mon_en = 1'b1;
    endtask

    task automatic run_basic(input string tag, input bit tog);
        bit to;
        int lat;
        logic [UBN-1:0] u[4];
        u = '{32'haa55aa55, 32'h55667788, 32'h11223344, 32'hffeeddcc};
        toggle_mode = tog;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(u[i]);
            exp_q.push_back(u[i]);
        end
        tick(2);
        start_frame(8'd4, 8'd1);
        checks++;
        if (bus.BUSY_O !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 1 after START", tag, bus.BUSY_O);
        end
        bus.UNIT_NUM_I  = 8'd1;
        bus.CYCLE_NUM_I = 8'd9;
        lat = 0;
        while (!bus.DE_O && lat < 10) begin
            tick(1);
            lat++;
        end
        if (!tog) begin
            checks++;
            if (lat < 2 || lat > 3) begin
                errors++;
                $display("FAIL %s_latency: DE rose %0d cycles after START, expected 2 or 3", tag, lat);
            end
        end
        checks++;
        if ({bus.DQ1_O, bus.DQ0_O} !== 2'b01) begin
            errors++;
            $display("FAIL %s_first_pair: dq1/dq0=%b%b expected 01", tag, bus.DQ1_O, bus.DQ0_O);
        end
        wait_idle(1000, to);
        checks++;
        if (to || de_cyc != 128 || bursts != 1) begin
            errors++;
            $display("FAIL %s_de: timeout=%0d de_cycles=%0d bursts=%0d, expected 0/128/1", tag, to, de_cyc, bursts);
        end
        checks++;
        if (done_cnt != 1 || und_cnt != 0) begin
            errors++;
            $display("FAIL %s_pulses: done=%0d underrun=%0d, expected 1/0", tag, done_cnt, und_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || bus.UNIT_READY_O !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: units left=%0d ready=%b, expected 0/0", tag, exp_q.size(), bus.UNIT_READY_O);
        end
        toggle_mode = 1'b0;
    endtask

    task automatic test_basic();
        run_basic("basic", 1'b0);
    endtask

    task automatic test_back_pressure();
        run_basic("toggle", 1'b1);
    endtask

    task automatic test_gap();
        bit to;
        int g0, g1;
        logic [UBN-1:0] v;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            src_q.push_back(v);
            exp_q.push_back(v);
        end
        tick(2);
        start_frame(8'd2, 8'd3);
        tick(20);
        start_frame(8'd1, 8'd1);
        wait_idle(2000, to);
        g0 = (gaps.size() > 0) ? gaps[0] : -1;
        g1 = (gaps.size() > 1) ? gaps[1] : -1;
        checks++;
        if (to || bursts != 3 || de_cyc != 192) begin
            errors++;
            $display("FAIL gap_bursts: timeout=%0d bursts=%0d de_cycles=%0d, expected 0/3/192", to, bursts, de_cyc);
        end
        checks++;
        if (gaps.size() != 2 || g0 != 4 || g1 != 4) begin
            errors++;
            $display("FAIL gap_len: count=%0d gaps=%0d,%0d, expected 2 gaps of 4", gaps.size(), g0, g1);
        end
        checks++;
        if (done_cnt != 1 || und_cnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gap_end: done=%0d underrun=%0d units left=%0d, expected 1/0/0", done_cnt, und_cnt, exp_q.size());
        end
    endtask

    task automatic test_underrun();
        bit to;
        int r0;
        clear_mon();
        src_q.push_back(32'h0badcafe);
        exp_q.push_back(32'h0badcafe);
        tick(2);
        start_frame(8'd2, 8'd1);
        wait_idle(500, to);
        checks++;
        if (to || und_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL underrun_pulses: timeout=%0d underrun=%0d done=%0d, expected 0/1/0", to, und_cnt, done_cnt);
        end
        checks++;
        if (de_cyc != 32 || exp_q.size() != 0 || bus.BUSY_O !== 1'b0) begin
            errors++;
            $display("FAIL underrun_de: de_cycles=%0d units left=%0d busy=%b, expected 32/0/0", de_cyc, exp_q.size(), bus.BUSY_O);
        end
        r0 = rdy_cyc;
        src_q.push_back(32'h12345678);
        tick(6);
        checks++;
        if (rdy_cyc != r0 || src_q.size() != 1) begin
            errors++;
            $display("FAIL underrun_idle_ready: ready cycles %0d->%0d, source left %0d, expected no change and 1", r0, rdy_cyc, src_q.size());
        end
        src_q.delete();
        tick(2);
    endtask

    task automatic test_illegal();
        logic [7:0] un[3];
        logic [7:0] cn[3];
        un = '{8'd0, 8'd1, 8'd5};
        cn = '{8'd1, 8'd0, 8'd1};
        clear_mon();
        src_q.push_back(32'hdeadbeef);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            start_frame(un[i], cn[i]);
            tick(6);
            checks++;
            if (bus.BUSY_O !== 1'b0) begin
                errors++;
                $display("FAIL illegal_busy: unit_num=%0d cycle_num=%0d busy=%b, expected 0", un[i], cn[i], bus.BUSY_O);
            end
        end
        checks++;
        if (de_cyc != 0 || rdy_cyc != 0 || done_cnt != 0 || und_cnt != 0 || src_q.size() != 1) begin
            errors++;
            $display("FAIL illegal_quiet: de=%0d ready=%0d done=%0d underrun=%0d source left=%0d, expected 0/0/0/0/1",
                     de_cyc, rdy_cyc, done_cnt, und_cnt, src_q.size());
        end
        src_q.delete();
        tick(2);
    endtask

    task automatic test_reset_mid();
        bit to;
        int w;
        logic [UBN-1:0] v;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(32'h01010101 * (i + 1));
            exp_q.push_back(32'h01010101 * (i + 1));
        end
        tick(2);
        start_frame(8'd4, 8'd1);
        w = 0;
        while (!bus.DE_O && w < 10) begin
            tick(1);
            w++;
        end
        tick(79);
        allow_partial = 1'b1;
        RST_I = 1'b1;
        tick(1);
        checks++;
        if (out_vec() !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 00000000", out_vec());
        end
        RST_I = 1'b0;
        src_q.delete();
        exp_q.delete();
        tick(4);
        checks++;
        if (done_cnt != 0 || und_cnt != 0 || bus.BUSY_O !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pulses: done=%0d underrun=%0d busy=%b, expected 0/0/0", done_cnt, und_cnt, bus.BUSY_O);
        end
        allow_partial = 1'b0;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            src_q.push_back(v);
            exp_q.push_back(v);
        end
        tick(2);
        start_frame(8'd4, 8'd1);
        wait_idle(1000, to);
        checks++;
        if (to || de_cyc != 128 || done_cnt != 1 || und_cnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_next: timeout=%0d de=%0d done=%0d underrun=%0d units left=%0d, expected 0/128/1/0/0",
                     to, de_cyc, done_cnt, und_cnt, exp_q.size());
        end
    endtask

    initial begin
        bus.START_I     = 1'b0;
        bus.UNIT_NUM_I  = 8'd0;
        bus.CYCLE_NUM_I = 8'd0;
        test_reset();
        test_basic();
        test_gap();
        test_underrun();
        test_illegal();
        test_back_pressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
